// File: rtl/control_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller (drives control fields), slave = datapath (drives opcode and flags).
interface control_fsm_if;
  logic [6:0] op;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic [3:0] state;

  modport master (
    input  op, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ALUOp, ImmSrc, state
  );

  modport slave (
    output op, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ALUOp, ImmSrc, state
  );
endinterface

// File: rtl/control_fsm.sv
// Moore controller for a multicycle RISC-V subset (lw/sw/R/I/beq/jal); outputs registered
// alongside state, except PCWrite (branch AND Zero) and ImmSrc (decoded from op).
module control_fsm (
  input  logic          clk,
  input  logic          rst,
  control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // FETCH selects with the PC and IR enables held off while in reset.
  localparam ctrl_t CTRL_RST = '{
    pc_update: 1'b0, branch: 1'b0, adr_src: 1'b0, mem_write: 1'b0, ir_write: 1'b0,
    result_src: 2'b10, alu_src_a: 2'b00, alu_src_b: 2'b10, reg_write: 1'b0, alu_op: 2'b00
  };

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   run_q, run_d;

  // The first edge out of reset re-enters FETCH so its enables get a full cycle.
  always_comb begin
    run_d   = 1'b1;
    state_d = FETCH;
    if (run_q) begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_R:         state_d = EXECUTER;
            OP_I:         state_d = EXECUTEI;
            OP_BEQ:       state_d = BEQ;
            OP_JAL:       state_d = JAL;
            default:      state_d = FETCH;
          endcase
        end
        MEMADR: begin
          if (bus.op == OP_LW)      state_d = MEMREAD;
          else if (bus.op == OP_SW) state_d = MEMWRITE;
          else                      state_d = FETCH;
        end
        MEMREAD:  state_d = MEMWB;
        EXECUTER: state_d = ALUWB;
        EXECUTEI: state_d = ALUWB;
        JAL:      state_d = ALUWB;
        default:  state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl_d = '0;
    case (state_d)
      FETCH: begin
        ctrl_d.ir_write   = 1'b1;
        ctrl_d.alu_src_b  = 2'b10;
        ctrl_d.result_src = 2'b10;
        ctrl_d.pc_update  = 1'b1;
      end
      DECODE: begin
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.alu_src_b = 2'b01;
      end
      MEMADR: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_src_b = 2'b01;
      end
      MEMREAD: ctrl_d.adr_src = 1'b1;
      MEMWB: begin
        ctrl_d.result_src = 2'b01;
        ctrl_d.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      EXECUTER: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_op    = 2'b10;
      end
      EXECUTEI: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.alu_op    = 2'b10;
      end
      ALUWB: ctrl_d.reg_write = 1'b1;
      BEQ: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_op    = 2'b01;
        ctrl_d.branch    = 1'b1;
      end
      JAL: begin
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.pc_update = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
      ctrl_q  <= CTRL_RST;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  assign bus.PCWrite   = ctrl_q.pc_update | (ctrl_q.branch & bus.Zero);
  assign bus.AdrSrc    = ctrl_q.adr_src;
  assign bus.MemWrite  = ctrl_q.mem_write;
  assign bus.IRWrite   = ctrl_q.ir_write;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.ALUSrcA   = ctrl_q.alu_src_a;
  assign bus.ALUSrcB   = ctrl_q.alu_src_b;
  assign bus.RegWrite  = ctrl_q.reg_write;
  assign bus.ALUOp     = ctrl_q.alu_op;
  assign bus.state     = state_q;
endmodule
